// File: rtl/spi_arb_pkg.sv
// Shared state encoding and width helper for the SPI bus arbiter.
package spi_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Ceiling log2, used to size the winner index and the timeout counter.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 32'sd0;
    rem    = value - 32'sd1;
    while (rem > 32'sd0) begin
      result = result + 32'sd1;
      rem    = rem / 32'sd2;
    end
    return result;
  endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [IDX_W-1:0] slot_s [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slot
    assign slot_s[k] = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
  end

  // Walk from the farthest slot back to rr_ptr so the nearest requester is the one left standing.
  always_comb begin
    gnt = {NUM_REQ{1'b0}};
    idx = {IDX_W{1'b0}};
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      gnt = req[slot_s[k]] ? (ONE << slot_s[k]) : gnt;
      idx = req[slot_s[k]] ? slot_s[k] : idx;
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one spi_master between NUM_REQ requesters,
// with per-transaction timeout and one-hot device select.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 65535
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          err,
  output logic                          busy,
  output logic [NUM_REQ-1:0]            dev_sel,
  output logic                          m_start,
  output logic [DATA_WIDTH-1:0]         m_data_in,
  input  logic                          m_finish,
  input  logic [DATA_WIDTH-1:0]         m_data_out
);

  localparam int IDX_W = clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 32'sd0) ? clog2(TIMEOUT + 32'sd1) : 32'sd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [1:0]            state_r;
  logic [IDX_W-1:0]      win_idx_r;
  logic [IDX_W-1:0]      rr_ptr_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [NUM_REQ-1:0]    pick_gnt_s;
  logic [IDX_W-1:0]      pick_idx_s;
  logic [IDX_W-1:0]      next_ptr_s;
  logic                  timeout_s;
  logic [DATA_WIDTH-1:0] words_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words_s[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_r),
    .gnt    (pick_gnt_s),
    .idx    (pick_idx_s)
  );

  assign timeout_s  = (TIMEOUT != 32'sd0) && (cnt_r == CNT_LAST);
  assign next_ptr_s = (win_idx_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}} : win_idx_r + 1'b1;

  // Transaction sequencer; m_finish is tested before the timeout so it wins a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      win_idx_r <= {IDX_W{1'b0}};
      rr_ptr_r  <= {IDX_W{1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      ack       <= {NUM_REQ{1'b0}};
      rdata     <= {DATA_WIDTH{1'b0}};
      err       <= 1'b0;
      busy      <= 1'b0;
      dev_sel   <= {NUM_REQ{1'b0}};
      m_start   <= 1'b0;
      m_data_in <= {DATA_WIDTH{1'b0}};
    end else begin
      m_start <= 1'b0;
      ack     <= {NUM_REQ{1'b0}};
      case (state_r)
        IDLE: begin
          if (|req) begin
            win_idx_r <= pick_idx_s;
            dev_sel   <= pick_gnt_s;
            m_data_in <= words_s[pick_idx_s];
            m_start   <= 1'b1;
            busy      <= 1'b1;
            state_r   <= START;
          end
        end
        START: begin
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= WAIT;
        end
        WAIT: begin
          if (m_finish) begin
            rdata   <= m_data_out;
            err     <= 1'b0;
            ack     <= dev_sel;
            state_r <= RESP;
          end else if (timeout_s) begin
            rdata   <= {DATA_WIDTH{1'b0}};
            err     <= 1'b1;
            ack     <= dev_sel;
            state_r <= RESP;
          end else if (cnt_r != CNT_MAX) begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        RESP: begin
          rr_ptr_r <= next_ptr_s;
          dev_sel  <= {NUM_REQ{1'b0}};
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          dev_sel <= {NUM_REQ{1'b0}};
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Bench for spi_bus_arbiter: transaction-timeline model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_spi_bus_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int TO = 50;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR-1:0]     ack;
  logic [DW-1:0]     rdata;
  logic              err;
  logic              busy;
  logic [NR-1:0]     dev_sel;
  logic              m_start;
  logic [DW-1:0]     m_data_in;
  logic              m_finish;
  logic [DW-1:0]     m_data_out;

  spi_bus_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy), .dev_sel(dev_sel),
    .m_start(m_start), .m_data_in(m_data_in), .m_finish(m_finish), .m_data_out(m_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;
  int cyc;

  logic [NR-1:0]    s_req;
  logic [NR*DW-1:0] s_wd;
  logic             s_fin;
  logic [DW-1:0]    s_dout;

  // Cycle number and the inputs the DUT saw at this edge.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    s_req  <= req;
    s_wd   <= req_wdata;
    s_fin  <= m_finish;
    s_dout <= m_data_out;
  end

  // Model: one transaction at a time, described by its owner, start cycle and ack cycle.
  bit            md_busy;
  int            md_owner, md_start, md_done, md_ptr;
  logic [DW-1:0] md_word, md_rdata;
  logic          md_err;

  int            ack_idx_q[$];
  int            ack_cyc_q[$];
  logic [DW-1:0] ack_rd_q[$];
  logic          ack_err_q[$];
  int            st_cyc_q[$];
  logic [NR-1:0] st_dev_q[$];
  logic [DW-1:0] st_data_q[$];

  int            slave_lat;
  bit            slave_fix;
  logic [DW-1:0] slave_word;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [NR-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NR; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic model_step();
    int t;
    int k;
    t = cyc;
    if (!rst_n) begin
      md_busy = 1'b0; md_ptr = 0; md_owner = 0; md_start = -1; md_done = -1;
      md_word = '0; md_rdata = '0; md_err = 1'b0;
    end else if (!md_busy) begin
      if (s_req != '0) begin
        k = 0;
        while (!s_req[(md_ptr + k) % NR]) k++;
        md_owner = (md_ptr + k) % NR;
        md_busy  = 1'b1;
        md_start = t;
        md_done  = -1;
        md_word  = s_wd[md_owner*DW +: DW];
      end
    end else if (md_done >= 0) begin
      if (t > md_done) begin
        md_busy = 1'b0;
        md_ptr  = (md_owner + 1) % NR;
      end
    end else if (t - 1 > md_start) begin
      if (s_fin) begin
        md_done = t; md_rdata = s_dout; md_err = 1'b0;
      end else if (t - 1 == md_start + TO) begin
        md_done = t; md_rdata = '0; md_err = 1'b1;
      end
    end
  endtask

  // Compare process: every cycle, all outputs against the model, and log acks/starts.
  initial begin
    md_busy = 1'b0; md_ptr = 0; md_owner = 0; md_start = -1; md_done = -1;
    md_word = '0; md_rdata = '0; md_err = 1'b0;
    forever begin
      @(negedge clk);
      model_step();
      chk("busy",      busy,      md_busy);
      chk("dev_sel",   dev_sel,   md_busy ? oh(md_owner) : {NR{1'b0}});
      chk("m_start",   m_start,   md_busy && (cyc == md_start));
      chk("ack",       ack,       (md_busy && cyc == md_done) ? oh(md_owner) : {NR{1'b0}});
      chk("m_data_in", m_data_in, md_word);
      chk("rdata",     rdata,     md_rdata);
      chk("err",       err,       md_err);
      if (rst_n && ack != '0) begin
        ack_idx_q.push_back(idx_of(ack)); ack_cyc_q.push_back(cyc);
        ack_rd_q.push_back(rdata);        ack_err_q.push_back(err);
      end
      if (rst_n && m_start) begin
        st_cyc_q.push_back(cyc); st_dev_q.push_back(dev_sel); st_data_q.push_back(m_data_in);
      end
    end
  end

  // Slave model: answers slave_lat cycles after m_start; latencies beyond TO never answer.
  initial begin
    int   fin_at;
    int   lat;
    bit   pend;
    logic st;
    logic rs;
    m_finish = 1'b0; m_data_out = '0; pend = 1'b0; fin_at = 0;
    forever begin
      @(negedge clk);
      st = m_start;
      rs = rst_n;
      #1;
      m_finish   = 1'b0;
      m_data_out = DW'($urandom);
      if (!rs) begin
        pend = 1'b0;
      end else if (st) begin
        lat    = (slave_lat < 0) ? int'($urandom_range(55, 1)) : slave_lat;
        pend   = (lat <= TO);
        fin_at = cyc + lat;
      end else if (pend && cyc == fin_at) begin
        m_finish   = 1'b1;
        pend       = 1'b0;
        m_data_out = slave_fix ? slave_word : DW'($urandom);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [DW-1:0] w);
    req_wdata[i*DW +: DW] = w;
  endtask

  task automatic clear_logs();
    ack_idx_q.delete(); ack_cyc_q.delete(); ack_rd_q.delete(); ack_err_q.delete();
    st_cyc_q.delete(); st_dev_q.delete(); st_data_q.delete();
  endtask

  task automatic wait_acks(input int n, input int budget, input string nm);
    int k;
    k = 0;
    while (ack_idx_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    chk(nm, ack_idx_q.size() >= n, 1'b1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1);
  end

  initial begin
    int exp_order[5];
    int req_cyc;
    exp_order = '{0, 1, 2, 3, 0};
    rst_n = 1'b0; req = '0; req_wdata = '0;
    slave_lat = 3; slave_fix = 1'b0; slave_word = '0;
    tick(3);
    rst_n = 1'b1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_dev_sel", dev_sel, 4'b0000);
    chk("reset_m_data_in", m_data_in, 16'h0000);

    // Fairness from rr_ptr=0 with all four requesting continuously.
    clear_logs();
    for (int i = 0; i < NR; i++) set_word(i, 16'h1000 + 16'(i) * 16'h0111);
    req = 4'b1111;
    wait_acks(5, 200, "fair_wait");
    req = 4'b0000;
    if (ack_idx_q.size() >= 5 && st_cyc_q.size() >= 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("fair_order", ack_idx_q[k], exp_order[k]);
        chk("fair_word", st_data_q[k], 16'h1000 + 16'(exp_order[k]) * 16'h0111);
      end
      chk("fair_latency", ack_cyc_q[0] - st_cyc_q[0], 4);
      chk("fair_gap", st_cyc_q[1] - ack_cyc_q[0], 2);
    end
    tick(3);

    // Single request to requester 1.
    clear_logs();
    set_word(1, 16'hA5C3); slave_fix = 1'b1; slave_word = 16'h1234; slave_lat = 5;
    req = 4'b0010; req_cyc = cyc;
    wait_acks(1, 100, "single_wait");
    req = 4'b0000;
    tick(4);
    chk("single_starts", st_cyc_q.size(), 1);
    if (st_cyc_q.size() >= 1 && ack_idx_q.size() >= 1) begin
      chk("single_grant_lat", st_cyc_q[0] - req_cyc, 1);
      chk("single_dev_sel", st_dev_q[0], 4'b0010);
      chk("single_m_data_in", st_data_q[0], 16'hA5C3);
      chk("single_ack_idx", ack_idx_q[0], 1);
      chk("single_rdata", ack_rd_q[0], 16'h1234);
      chk("single_err", ack_err_q[0], 1'b0);
    end

    // Serve requester 2 to leave rr_ptr at 3, then wrap-around.
    req = 4'b0100;
    wait_acks(2, 100, "prewrap_wait");
    req = 4'b0000;
    tick(3);
    clear_logs();
    req = 4'b1001;
    wait_acks(2, 100, "wrap_wait");
    req = 4'b0000;
    if (ack_idx_q.size() >= 2) begin
      chk("wrap_first", ack_idx_q[0], 3);
      chk("wrap_second", ack_idx_q[1], 0);
    end
    tick(3);

    // Timeout, then a normal transaction whose finish ties with the timeout.
    clear_logs();
    slave_lat = 99; set_word(1, 16'h7777);
    req = 4'b0010;
    wait_acks(1, 120, "timeout_wait");
    req = 4'b0000;
    if (ack_idx_q.size() >= 1 && st_cyc_q.size() >= 1) begin
      chk("timeout_latency", ack_cyc_q[0] - st_cyc_q[0], 51);
      chk("timeout_err", ack_err_q[0], 1'b1);
      chk("timeout_rdata", ack_rd_q[0], 16'h0000);
    end
    tick(3);
    clear_logs();
    slave_lat = TO; slave_word = 16'hBEEF;
    req = 4'b0100;
    wait_acks(1, 120, "tie_wait");
    req = 4'b0000;
    if (ack_idx_q.size() >= 1 && st_cyc_q.size() >= 1) begin
      chk("tie_latency", ack_cyc_q[0] - st_cyc_q[0], 51);
      chk("tie_err", ack_err_q[0], 1'b0);
      chk("tie_rdata", ack_rd_q[0], 16'hBEEF);
    end
    tick(3);

    // Reset during WAIT, then rr_ptr must restart at 0.
    clear_logs();
    slave_lat = 99;
    req = 4'b1000;
    tick(8);
    chk("rst_pre_busy", busy, 1'b1);
    rst_n = 1'b0; req = 4'b0000;
    tick(3);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dev_sel", dev_sel, 4'b0000);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_m_data_in", m_data_in, 16'h0000);
    rst_n = 1'b1;
    chk("rst_no_ack", ack_idx_q.size(), 0);
    slave_lat = 2;
    req = 4'b1100;
    wait_acks(2, 100, "post_rst_wait");
    req = 4'b0000;
    if (ack_idx_q.size() >= 2) begin
      chk("post_rst_first", ack_idx_q[0], 2);
      chk("post_rst_second", ack_idx_q[1], 3);
    end
    tick(3);

    // Request withdrawn while the transfer is in flight.
    clear_logs();
    slave_lat = 20; slave_word = 16'h5A5A;
    req = 4'b0001;
    tick(6);
    req = 4'b0000;
    wait_acks(1, 100, "drop_wait");
    tick(30);
    chk("drop_starts", st_cyc_q.size(), 1);
    chk("drop_acks", ack_idx_q.size(), 1);
    if (ack_idx_q.size() >= 1) begin
      chk("drop_idx", ack_idx_q[0], 0);
      chk("drop_rdata", ack_rd_q[0], 16'h5A5A);
      chk("drop_err", ack_err_q[0], 1'b0);
    end

    // Randomized traffic, checked by the per-cycle model.
    slave_fix = 1'b0; slave_lat = -1;
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (req[i] && ack[i]) begin
          if ($urandom_range(3, 0) != 0) req[i] = 1'b0;
          else set_word(i, DW'($urandom));
        end else if (!req[i] && $urandom_range(5, 0) == 0) begin
          set_word(i, DW'($urandom));
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(199, 0) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(1499, 0) == 0) begin
        rst_n = 1'b0;
        tick($urandom_range(3, 1));
        rst_n = 1'b1;
      end
      tick(1);
    end
    req = '0;
    tick(80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
